// File: rtl/dpll_loop_sequencer.sv
// Bit-clock recovery loop sequencer: range-checks and loads the estimated NCO word,
// steps the DPLL from acquisition to tracking gains, then qualifies and supervises lock.
module dpll_loop_sequencer #(
  parameter logic [31:0] FREQ_MIN = 32'h0100_0000,
  parameter logic [31:0] FREQ_MAX = 32'h4000_0000,
  parameter int unsigned ACQ_BITS = 256,
  parameter logic [15:0] LOCK_WIN = 16'd64,
  parameter int unsigned LOCK_CNT = 64,
  parameter int unsigned LOSS_CNT = 16,
  parameter logic [3:0]  KP_ACQ   = 4'd4,
  parameter logic [3:0]  KI_ACQ   = 4'd8,
  parameter logic [3:0]  KP_TRK   = 4'd7,
  parameter logic [3:0]  KI_TRK   = 4'd12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        est_done,
  input  logic [31:0] quotient,
  input  logic        activity,
  input  logic        transition,
  input  logic [15:0] phase_err,
  input  logic [31:0] freq_int,
  output logic        nco_load,
  output logic [31:0] nco_word,
  output logic        loop_en,
  output logic [3:0]  kp_shift,
  output logic [3:0]  ki_shift,
  output logic        lock,
  output logic        lock_err,
  output logic        outside_freq_range,
  output logic [2:0]  ctl_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ACQ   = 3'd2,
    TRACK = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Estimator result is registered once, giving the two-clock est_done -> nco_load latency.
  logic        est_done_reg;
  logic [31:0] quotient_reg;

  logic [9:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  good_cnt_reg, good_cnt_next;
  logic [7:0]  bad_cnt_reg, bad_cnt_next;

  logic        nco_load_next, loop_en_next, lock_next, lock_err_next, ofr_next;
  logic [31:0] nco_word_next;
  logic [3:0]  kp_next, ki_next;

  logic [15:0] pe_mag;
  logic        bit_good;
  logic [7:0]  good_inc, bad_inc;

  function automatic logic in_range(input logic [31:0] w);
    return (w >= FREQ_MIN) && (w <= FREQ_MAX);
  endfunction

  // Most negative error folds to the largest positive magnitude.
  always_comb begin
    pe_mag = phase_err;
    if (phase_err == 16'h8000) begin
      pe_mag = 16'h7FFF;
    end else if (phase_err[15]) begin
      pe_mag = 16'd0 - phase_err;
    end
  end

  assign bit_good = (pe_mag <= LOCK_WIN);
  assign good_inc = (good_cnt_reg == 8'hFF) ? good_cnt_reg : good_cnt_reg + 8'd1;
  assign bad_inc  = (bad_cnt_reg == 8'hFF) ? bad_cnt_reg : bad_cnt_reg + 8'd1;

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    good_cnt_next = good_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    nco_word_next = nco_word;
    lock_err_next = lock_err;
    ofr_next      = outside_freq_range;

    if (restart) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (est_done_reg) begin
            if (in_range(quotient_reg)) begin
              nco_word_next = quotient_reg;
              lock_err_next = 1'b0;
              ofr_next      = 1'b0;
              state_next    = LOAD;
            end else begin
              ofr_next = 1'b1;
            end
          end
        end
        LOAD: begin
          if (!activity) begin
            state_next = IDLE;
          end else begin
            bit_cnt_next  = '0;
            good_cnt_next = '0;
            bad_cnt_next  = '0;
            state_next    = ACQ;
          end
        end
        ACQ: begin
          if (!activity) begin
            state_next = IDLE;
          end else if (transition) begin
            if (bit_cnt_reg == 10'(ACQ_BITS - 1)) begin
              bit_cnt_next = '0;
              state_next   = TRACK;
            end else begin
              bit_cnt_next = bit_cnt_reg + 10'd1;
            end
          end
        end
        TRACK: begin
          if (!in_range(freq_int)) begin
            ofr_next      = 1'b1;
            lock_err_next = 1'b1;
            state_next    = FAULT;
          end else if (!activity) begin
            state_next = IDLE;
          end else if (transition) begin
            if (bit_good) begin
              good_cnt_next = good_inc;
              bad_cnt_next  = '0;
            end else begin
              good_cnt_next = '0;
              bad_cnt_next  = bad_inc;
              if (bad_inc == 8'(LOSS_CNT)) begin
                if (lock) begin
                  lock_err_next = 1'b1;
                  state_next    = FAULT;
                end else begin
                  // Never qualified: quietly start acquisition over.
                  bit_cnt_next  = '0;
                  good_cnt_next = '0;
                  bad_cnt_next  = '0;
                  state_next    = ACQ;
                end
              end
            end
          end
        end
        FAULT: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Registered outputs follow the state being entered on this edge.
  always_comb begin
    nco_load_next = (state_next == LOAD);
    loop_en_next  = (state_next == ACQ) || (state_next == TRACK);
    lock_next     = (state_next == TRACK) && (lock || (good_cnt_next == 8'(LOCK_CNT)));
    kp_next       = kp_shift;
    ki_next       = ki_shift;
    if (state_next == TRACK) begin
      kp_next = KP_TRK;
      ki_next = KI_TRK;
    end else if ((state_next == ACQ) || (state_next == LOAD)) begin
      kp_next = KP_ACQ;
      ki_next = KI_ACQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      est_done_reg       <= 1'b0;
      quotient_reg       <= '0;
      bit_cnt_reg        <= '0;
      good_cnt_reg       <= '0;
      bad_cnt_reg        <= '0;
      nco_load           <= 1'b0;
      nco_word           <= '0;
      loop_en            <= 1'b0;
      kp_shift           <= KP_ACQ;
      ki_shift           <= KI_ACQ;
      lock               <= 1'b0;
      lock_err           <= 1'b0;
      outside_freq_range <= 1'b0;
    end else begin
      state_reg          <= state_next;
      est_done_reg       <= est_done;
      quotient_reg       <= quotient;
      bit_cnt_reg        <= bit_cnt_next;
      good_cnt_reg       <= good_cnt_next;
      bad_cnt_reg        <= bad_cnt_next;
      nco_load           <= nco_load_next;
      nco_word           <= nco_word_next;
      loop_en            <= loop_en_next;
      kp_shift           <= kp_next;
      ki_shift           <= ki_next;
      lock               <= lock_next;
      lock_err           <= lock_err_next;
      outside_freq_range <= ofr_next;
    end
  end

  assign ctl_state = state_reg;

endmodule

// File: tb/tb_dpll_loop_sequencer.sv
// Self-checking bench for dpll_loop_sequencer: vector tables, directed corner
// sequences and randomized tracking scenarios scored by a run-length model.
module tb_dpll_loop_sequencer;

  localparam logic [31:0] FMIN = 32'h0100_0000;
  localparam logic [31:0] FMAX = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst, restart, est_done, activity, transition;
  logic [31:0] quotient, freq_int;
  logic [15:0] phase_err;
  logic        nco_load, loop_en, lock, lock_err, outside_freq_range;
  logic [31:0] nco_word;
  logic [3:0]  kp_shift, ki_shift;
  logic [2:0]  ctl_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dpll_loop_sequencer dut (
    .clk(clk), .rst(rst), .restart(restart), .est_done(est_done), .quotient(quotient),
    .activity(activity), .transition(transition), .phase_err(phase_err), .freq_int(freq_int),
    .nco_load(nco_load), .nco_word(nco_word), .loop_en(loop_en), .kp_shift(kp_shift),
    .ki_shift(ki_shift), .lock(lock), .lock_err(lock_err),
    .outside_freq_range(outside_freq_range), .ctl_state(ctl_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [15:0] pe);
    transition = 1'b1;
    phase_err  = pe;
    tick();
    transition = 1'b0;
  endtask

  // Abort, present a quotient, and run until the loop sits in ACQ.
  task automatic start(input logic [31:0] q);
    restart = 1'b1; tick(); restart = 1'b0;
    est_done = 1'b1; quotient = q; tick(); est_done = 1'b0;
    tick();
    tick();
  endtask

  task automatic acquire();
    for (int i = 0; i < 256; i++) xfer(16'($urandom));
  endtask

  task automatic lock_up();
    for (int i = 0; i < 64; i++) xfer(16'd0);
  endtask

  function automatic logic [15:0] good_pe();
    int v;
    v = int'($urandom_range(0, 128)) - 64;
    return 16'(v);
  endfunction

  function automatic logic [15:0] bad_pe();
    int v;
    if ($urandom_range(0, 7) == 0) return 16'h8000;
    v = int'($urandom_range(65, 32767));
    if ($urandom_range(0, 1) == 1) v = -v;
    return 16'(v);
  endfunction

  typedef struct {
    logic [31:0] q;
    logic        accept;
  } qvec_t;

  typedef struct {
    logic [15:0] pe;
    logic        good;
  } pvec_t;

  qvec_t qtab[7];
  pvec_t ptab[9];

  initial begin
    logic [31:0] last_word;

    qtab[0] = '{32'h0200_0000, 1'b1};
    qtab[1] = '{32'h4000_0001, 1'b0};
    qtab[2] = '{FMIN,          1'b1};
    qtab[3] = '{32'h00FF_FFFF, 1'b0};
    qtab[4] = '{FMAX,          1'b1};
    qtab[5] = '{32'hFFFF_FFFF, 1'b0};
    qtab[6] = '{32'h0000_0000, 1'b0};

    ptab[0] = '{16'h0000, 1'b1};
    ptab[1] = '{16'h0040, 1'b1};
    ptab[2] = '{16'hFFC0, 1'b1};
    ptab[3] = '{16'h0041, 1'b0};
    ptab[4] = '{16'hFFBF, 1'b0};
    ptab[5] = '{16'h8000, 1'b0};
    ptab[6] = '{16'h7FFF, 1'b0};
    ptab[7] = '{16'hFFFF, 1'b1};
    ptab[8] = '{16'h01F4, 1'b0};

    rst = 1'b1; restart = 1'b0; est_done = 1'b0; quotient = '0; activity = 1'b1;
    transition = 1'b0; phase_err = '0; freq_int = 32'h0200_0000;
    #2;
    chk("reset ctl_state", 32'(ctl_state), 0);
    chk("reset kp", 32'(kp_shift), 4);
    chk("reset ki", 32'(ki_shift), 8);
    chk("reset loop_en", 32'(loop_en), 0);
    chk("reset nco_word", nco_word, 0);
    chk("reset flags", {29'd0, lock, lock_err, outside_freq_range}, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    tick();

    // Quotient range table
    last_word = 32'h0;
    foreach (qtab[i]) begin
      restart = 1'b1; tick(); restart = 1'b0;
      est_done = 1'b1; quotient = qtab[i].q; tick(); est_done = 1'b0;
      chk("qtab early nco_load", 32'(nco_load), 0);
      tick();
      if (qtab[i].accept) last_word = qtab[i].q;
      $display("quotient %h accept=%0d", qtab[i].q, qtab[i].accept);
      chk("qtab nco_load", 32'(nco_load), 32'(qtab[i].accept));
      chk("qtab ctl_state", 32'(ctl_state), qtab[i].accept ? 1 : 0);
      chk("qtab outside_freq_range", 32'(outside_freq_range), 32'(!qtab[i].accept));
      chk("qtab nco_word", nco_word, last_word);
      tick();
      chk("qtab nco_load pulse", 32'(nco_load), 0);
    end

    // Directed: load latency, ACQ->TRACK, lock on 64th good bit, loss while locked
    restart = 1'b1; tick(); restart = 1'b0;
    est_done = 1'b1; quotient = 32'h0200_0000; tick(); est_done = 1'b0;
    tick();
    chk("seqA nco_load", 32'(nco_load), 1);
    chk("seqA nco_word", nco_word, 32'h0200_0000);
    chk("seqA loop_en early", 32'(loop_en), 0);
    tick();
    chk("seqA loop_en", 32'(loop_en), 1);
    chk("seqA ctl_state acq", 32'(ctl_state), 2);
    chk("seqA nco_load drop", 32'(nco_load), 0);
    for (int i = 0; i < 255; i++) xfer(16'd0);
    chk("seqA still acq", 32'(ctl_state), 2);
    chk("seqA acq kp", 32'(kp_shift), 4);
    xfer(16'd0);
    chk("seqA track", 32'(ctl_state), 3);
    chk("seqA trk kp", 32'(kp_shift), 7);
    chk("seqA trk ki", 32'(ki_shift), 12);
    for (int i = 0; i < 63; i++) xfer(16'd0);
    chk("seqA lock before 64th", 32'(lock), 0);
    xfer(16'd0);
    chk("seqA lock on 64th", 32'(lock), 1);
    for (int i = 0; i < 15; i++) xfer(16'sd500);
    chk("seqA lock held 15 bad", 32'(lock), 1);
    chk("seqA track 15 bad", 32'(ctl_state), 3);
    xfer(16'sd500);
    chk("seqA fault", 32'(ctl_state), 4);
    chk("seqA lock_err", 32'(lock_err), 1);
    chk("seqA fault lock", 32'(lock), 0);
    chk("seqA fault loop_en", 32'(loop_en), 0);
    tick();
    chk("seqA idle", 32'(ctl_state), 0);
    chk("seqA lock_err sticky", 32'(lock_err), 1);
    $display("seqA loss-of-lock sequence done");

    // Directed: freq_int runaway while locked, range boundaries legal, restart keeps flags
    start(32'h0300_0000); acquire(); lock_up();
    chk("seqB locked", 32'(lock), 1);
    chk("seqB flags cleared", {30'd0, lock_err, outside_freq_range}, 0);
    freq_int = FMIN; tick();
    chk("seqB fmin legal", 32'(ctl_state), 3);
    freq_int = FMAX; tick();
    chk("seqB fmax legal", 32'(ctl_state), 3);
    freq_int = 32'h00FF_FFFF; tick();
    freq_int = 32'h0200_0000;
    chk("seqB fault", 32'(ctl_state), 4);
    chk("seqB flags", {30'd0, lock_err, outside_freq_range}, 3);
    chk("seqB lock", 32'(lock), 0);
    tick();
    chk("seqB idle", 32'(ctl_state), 0);
    restart = 1'b1; tick(); restart = 1'b0;
    chk("seqB flags held on restart", {30'd0, lock_err, outside_freq_range}, 3);
    $display("seqB freq runaway sequence done");

    // Directed: activity loss in ACQ; est_done ignored outside IDLE
    start(32'h0280_0000);
    est_done = 1'b1; quotient = 32'h4000_0001; tick(); est_done = 1'b0; tick();
    chk("seqC est_done ignored state", 32'(ctl_state), 2);
    chk("seqC est_done ignored flag", 32'(outside_freq_range), 0);
    chk("seqC est_done ignored word", nco_word, 32'h0280_0000);
    activity = 1'b0; tick(); activity = 1'b1;
    chk("seqC activity idle", 32'(ctl_state), 0);
    chk("seqC activity loop_en", 32'(loop_en), 0);
    $display("seqC activity loss sequence done");

    // Directed: loss before lock restarts acquisition without lock_err
    start(32'h0200_0000); acquire();
    for (int i = 0; i < 15; i++) xfer(16'h8000);
    chk("seqD still track", 32'(ctl_state), 3);
    xfer(16'h8000);
    chk("seqD back to acq", 32'(ctl_state), 2);
    chk("seqD no lock_err", 32'(lock_err), 0);
    chk("seqD acq gains", {24'd0, kp_shift, ki_shift}, 32'h48);
    for (int i = 0; i < 255; i++) xfer(16'd0);
    chk("seqD reacq count", 32'(ctl_state), 2);
    xfer(16'd0);
    chk("seqD reacq track", 32'(ctl_state), 3);
    $display("seqD unlocked loss sequence done");

    // Directed: restart while locked, then async reset mid-TRACK
    lock_up();
    restart = 1'b1; tick(); restart = 1'b0;
    chk("seqE restart outputs", {29'd0, lock, loop_en, nco_load}, 0);
    chk("seqE restart idle", 32'(ctl_state), 0);
    start(32'h0200_0000); acquire(); lock_up();
    #2 rst = 1'b1; #1;
    chk("seqE rst state", 32'(ctl_state), 0);
    chk("seqE rst gains", {24'd0, kp_shift, ki_shift}, 32'h48);
    chk("seqE rst outputs", {28'd0, lock, loop_en, nco_load, lock_err}, 0);
    chk("seqE rst word", nco_word, 0);
    @(negedge clk); rst = 1'b0;
    tick();
    $display("seqE restart/reset sequence done");

    // Phase-error classification: 63 good bits then the vector decides lock
    foreach (ptab[i]) begin
      start(32'h0200_0000); acquire();
      for (int k = 0; k < 63; k++) xfer(16'd0);
      chk("ptab pre lock", 32'(lock), 0);
      xfer(ptab[i].pe);
      $display("phase vector %h good=%0d", ptab[i].pe, ptab[i].good);
      chk("ptab lock", 32'(lock), 32'(ptab[i].good));
    end

    // Randomized tracking scenarios scored against a run-length model
    for (int s = 0; s < 6; s++) begin
      logic [31:0] q;
      int run_good, run_bad, burst_start;
      bit locked, bad, done;
      q = FMIN + $urandom_range(0, FMAX - FMIN);
      start(q);
      chk("rand nco_word", nco_word, q);
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(0, 2) == 0) tick();
        xfer(16'($urandom));
      end
      chk("rand track", 32'(ctl_state), 3);
      run_good = 0; run_bad = 0; locked = 0; done = 0;
      burst_start = int'($urandom_range(5, 150));
      for (int i = 0; i < 200 && !done; i++) begin
        bad = ((i >= burst_start) && (i < burst_start + 20)) || ($urandom_range(0, 39) == 0);
        freq_int = FMIN + $urandom_range(0, FMAX - FMIN);
        if ($urandom_range(0, 3) == 0) begin
          tick();
          chk("rand gap lock", 32'(lock), 32'(locked));
        end
        xfer(bad ? bad_pe() : good_pe());
        if (bad) begin
          run_bad++; run_good = 0;
        end else begin
          run_good = (run_good < 255) ? run_good + 1 : 255; run_bad = 0;
        end
        if (run_good >= 64) locked = 1;
        if (run_bad == 16) begin
          done = 1;
          chk("rand loss state", 32'(ctl_state), locked ? 4 : 2);
          chk("rand loss lock_err", 32'(lock_err), 32'(locked));
          chk("rand loss lock", 32'(lock), 0);
        end else begin
          chk("rand state", 32'(ctl_state), 3);
          chk("rand lock", 32'(lock), 32'(locked));
        end
      end
      $display("scenario %0d q=%h burst=%0d locked=%0d", s, q, burst_start, locked);
      freq_int = 32'h0200_0000;
      restart = 1'b1; tick(); restart = 1'b0;
      chk("rand restart idle", 32'(ctl_state), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
